// File: rtl/spine_link_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spine_link_fifo
// Description : Egress buffer between a router spine output, which has no
//               backpressure, and the spine switch input. Bursts are
//               absorbed in a FIFO and presented as a valid/ready stream
//               with the destination address taken from each flit. Lost
//               flits are counted, and a link that stays blocked is flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module spine_link_fifo #(
   parameter int DWIDTH      = 16,
   parameter int ADDR_W      = 6,
   parameter int DEPTH       = 8,
   parameter int STALL_LIMIT = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DWIDTH-1:0]          in_data,
   input  logic                       in_valid,
   output logic [DWIDTH-1:0]          out_data,
   output logic                       out_valid,
   output logic [ADDR_W-1:0]          out_dest_addr,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty,
   output logic [15:0]                drop_count,
   output logic                       stall_flag
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_LVL_W = c_PTR_W + 1;
   localparam int c_CNT_W = $clog2(STALL_LIMIT + 1);

   localparam logic [c_LVL_W-1:0] c_DEPTH_LVL = c_LVL_W'(DEPTH);
   localparam logic [c_LVL_W-1:0] c_ONE_LVL   = c_LVL_W'(1);
   localparam logic [c_CNT_W-1:0] c_STALL_MAX = c_CNT_W'(STALL_LIMIT);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
   localparam logic [15:0]        c_DROP_MAX  = 16'hFFFF;

   // Link-state encoding
   localparam logic [1:0] c_ST_IDLE    = 2'd0;
   localparam logic [1:0] c_ST_ACTIVE  = 2'd1;
   localparam logic [1:0] c_ST_BLOCKED = 2'd2;

   logic [DWIDTH-1:0]  r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_LVL_W-1:0] r_level;
   logic [15:0]        r_drop_count;
   logic [1:0]         r_state;
   logic [c_CNT_W-1:0] r_stall_cnt;
   logic               r_stall_flag;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_drop;
   logic [1:0]         w_state_nxt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic [DWIDTH-1:0]  w_head;

   // Level is kept separately from the pointers so full and empty never alias
   assign w_full  = (r_level == c_DEPTH_LVL);
   assign w_empty = (r_level == '0);
   assign w_pop   = !w_empty & out_ready;
   // A full FIFO still accepts a flit when the head leaves in the same cycle
   assign w_push  = in_valid & (!w_full | w_pop);
   assign w_drop  = in_valid & w_full & !w_pop;

   // Empty storage reads as zero so stale flits never show after a flush
   assign w_head        = w_empty ? '0 : r_mem[r_rd_ptr];
   assign out_data      = w_head;
   assign out_dest_addr = w_head[DWIDTH-1 -: ADDR_W];
   assign out_valid     = !w_empty;
   assign level         = r_level;
   assign full          = w_full;
   assign empty         = w_empty;
   assign drop_count    = r_drop_count;
   assign stall_flag    = r_stall_flag;

   // Flit storage; contents need no reset because emptiness masks the head
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_push & !w_pop) begin
            r_level <= r_level + c_ONE_LVL;
         end else if (w_pop & !w_push) begin
            r_level <= r_level - c_ONE_LVL;
         end
      end
   end

   // Saturating count of flits lost to a full, non-draining FIFO
   always_ff @(posedge clk) begin
      if (reset) begin
         r_drop_count <= '0;
      end else if (w_drop && (r_drop_count != c_DROP_MAX)) begin
         r_drop_count <= r_drop_count + 16'd1;
      end
   end

   // Link-state next-state and stall counter logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_stall_cnt;
      case (r_state)
         c_ST_IDLE: begin
            if (w_push) begin
               w_state_nxt = c_ST_ACTIVE;
            end
         end
         c_ST_ACTIVE: begin
            if (!w_empty & !out_ready) begin
               w_state_nxt = c_ST_BLOCKED;
               w_cnt_nxt   = c_CNT_ONE;
            end else if ((w_empty | (w_pop & (r_level == c_ONE_LVL))) & !w_push) begin
               // Last flit leaves (or FIFO already drained after a block)
               w_state_nxt = c_ST_IDLE;
            end
         end
         c_ST_BLOCKED: begin
            if (w_pop) begin
               w_state_nxt = c_ST_ACTIVE;
               w_cnt_nxt   = '0;
            end else if (r_stall_cnt < c_STALL_MAX) begin
               w_cnt_nxt = r_stall_cnt + c_CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Link-state registers; the flag is registered off the next-state values
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= c_ST_IDLE;
         r_stall_cnt  <= '0;
         r_stall_flag <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_stall_cnt  <= w_cnt_nxt;
         r_stall_flag <= (w_state_nxt == c_ST_BLOCKED) && (w_cnt_nxt >= c_STALL_MAX);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spine_link_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_spine_link_fifo
// Description : Directed self-checking bench for spine_link_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spine_link_fifo;

   logic        clk;
   logic        reset;
   logic [15:0] in_data;
   logic        in_valid;
   logic [15:0] out_data;
   logic        out_valid;
   logic [5:0]  out_dest_addr;
   logic        out_ready;
   logic [3:0]  level;
   logic        full;
   logic        empty;
   logic [15:0] drop_count;
   logic        stall_flag;

   int n_checks;
   int n_errors;

   spine_link_fifo #(
      .DWIDTH      (16),
      .ADDR_W      (6),
      .DEPTH       (8),
      .STALL_LIMIT (64)
   ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_dest_addr (out_dest_addr),
      .out_ready     (out_ready),
      .level         (level),
      .full          (full),
      .empty         (empty),
      .drop_count    (drop_count),
      .stall_flag    (stall_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports a mismatch
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      chk("rst_level", level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_drops", drop_count, 0);
      chk("rst_stall", stall_flag, 0);

      // 1: single flit, one-cycle latency, address extraction
      out_ready = 1'b1;
      in_data   = 16'hA5C3;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 16'hA5C3);
      chk("t1_dest", out_dest_addr, 6'h29);
      step();
      chk("t1_empty", empty, 1);
      chk("t1_level", level, 0);

      // 2: fill, drop on full, ordered drain
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         in_data  = 16'(i);
         in_valid = 1'b1;
         step();
      end
      chk("t2_full", full, 1);
      chk("t2_level", level, 8);
      chk("t2_head", out_data, 16'h0001);
      in_data = 16'h0009;
      step();
      chk("t2_drop", drop_count, 1);
      chk("t2_level_after_drop", level, 8);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("t2_drain_valid", out_valid, 1);
         chk("t2_drain_data", out_data, 16'(i));
         step();
      end
      chk("t2_empty", empty, 1);

      // 3: full with simultaneous push/pop across the pointer wrap
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_data  = 16'h0010 + 16'(i);
         in_valid = 1'b1;
         step();
      end
      chk("t3_full", full, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 16'h0018 + 16'(i);
         chk("t3_level", level, 8);
         chk("t3_data", out_data, 16'h0010 + 16'(i));
         step();
      end
      in_valid = 1'b0;
      chk("t3_level_end", level, 8);
      chk("t3_no_drop", drop_count, 1);
      for (int i = 0; i < 8; i++) begin
         chk("t3_drain", out_data, 16'h0014 + 16'(i));
         step();
      end
      chk("t3_empty", empty, 1);

      // 4: stall flag after 64 blocked cycles, cleared after the pop
      out_ready = 1'b0;
      in_data   = 16'h4242;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (63) step();
      chk("t4_stall_63", stall_flag, 0);
      step();
      chk("t4_stall_64", stall_flag, 1);
      repeat (5) step();
      chk("t4_stall_hold", stall_flag, 1);
      chk("t4_data_held", out_data, 16'h4242);
      out_ready = 1'b1;
      step();
      chk("t4_stall_clear", stall_flag, 0);
      chk("t4_empty", empty, 1);

      // 5: reset mid-burst flushes everything
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_data  = 16'h0051 + 16'(i);
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      chk("t5_level_pre", level, 5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t5_level", level, 0);
      chk("t5_valid", out_valid, 0);
      chk("t5_drops", drop_count, 0);
      chk("t5_data", out_data, 0);
      out_ready = 1'b1;
      repeat (3) step();
      chk("t5_no_ghost", out_valid, 0);

      // 6: drop counter saturation
      out_ready = 1'b0;
      in_data   = 16'hDEAD;
      in_valid  = 1'b1;
      repeat (8) step();
      chk("t6_full", full, 1);
      repeat (65534) step();
      chk("t6_drops_fffe", drop_count, 16'hFFFE);
      step();
      chk("t6_drops_ffff", drop_count, 16'hFFFF);
      repeat (4465) step();
      chk("t6_drops_sat", drop_count, 16'hFFFF);
      in_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
